// File: rtl/cosim_run_ctrl_if.sv
// Host-side bundle of the co-simulation run controller: configuration, DUT
// activity, DUT control and the finish-request handshake.
interface cosim_run_ctrl_if;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned WORD_W = 32;

  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_max_cycles;
  logic [WORD_W-1:0] cfg_watchdog;
  logic [CNT_W-1:0]  cfg_trace_start;
  logic [CNT_W-1:0]  cfg_trace_end;
  logic              cfg_ready;
  logic              retire_valid;
  logic              exit_valid;
  logic [WORD_W-1:0] exit_code;
  logic              dut_reset;
  logic              trace_en;
  logic [CNT_W-1:0]  cycle_count;
  logic              quit_valid;
  logic [1:0]        quit_cause;
  logic [WORD_W-1:0] quit_code;
  logic              quit_ready;
  logic              done;

  modport master (
    output cfg_valid, cfg_max_cycles, cfg_watchdog, cfg_trace_start, cfg_trace_end,
    output retire_valid, exit_valid, exit_code, quit_ready,
    input  cfg_ready, dut_reset, trace_en, cycle_count,
    input  quit_valid, quit_cause, quit_code, done
  );

  modport slave (
    input  cfg_valid, cfg_max_cycles, cfg_watchdog, cfg_trace_start, cfg_trace_end,
    input  retire_valid, exit_valid, exit_code, quit_ready,
    output cfg_ready, dut_reset, trace_en, cycle_count,
    output quit_valid, quit_cause, quit_code, done
  );
endinterface

// File: rtl/cosim_run_ctrl.sv
// Co-simulation run controller: holds the DUT in reset after configuration,
// runs it until exit, watchdog or cycle limit, then hands a finish request out.
module cosim_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 5
) (
  input logic             clock,
  input logic             reset,
  cosim_run_ctrl_if.slave bus
);
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    QUIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  max_cycles_q;
  logic [CNT_W-1:0]  trace_start_q;
  logic [CNT_W-1:0]  trace_end_q;
  logic [WORD_W-1:0] watchdog_q;
  logic [WORD_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              exit_fire;
  logic              wd_fire;
  logic              lim_fire;
  logic [CNT_W-1:0]  count_inc;
  logic [CNT_W-1:0]  trace_cnt;
  logic [WORD_W-1:0] idle_nxt;
  logic              trace_nxt;

  // Fire detection and next-cycle counter values for the RUN state
  always_comb begin
    count_inc = bus.cycle_count + CNT_W'(1);
    exit_fire = (state == RUN) && bus.exit_valid;
    wd_fire   = (state == RUN) && (watchdog_q != '0) && (idle_cnt == watchdog_q)
                && !bus.retire_valid;
    lim_fire  = (state == RUN) && (max_cycles_q != '0) && (count_inc == max_cycles_q);
    if (bus.retire_valid)
      idle_nxt = '0;
    else if (&idle_cnt)
      idle_nxt = idle_cnt;
    else
      idle_nxt = idle_cnt + WORD_W'(1);
    // trace_en is registered, so it is judged on the count the next cycle will show
    trace_cnt = (state == RUN) ? count_inc : '0;
    trace_nxt = (trace_start_q <= trace_cnt) && (trace_cnt < trace_end_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      max_cycles_q    <= '0;
      trace_start_q   <= '0;
      trace_end_q     <= '0;
      watchdog_q      <= '0;
      idle_cnt        <= '0;
      hold_cnt        <= '0;
      bus.cfg_ready   <= 1'b1;
      bus.dut_reset   <= 1'b1;
      bus.trace_en    <= 1'b0;
      bus.cycle_count <= '0;
      bus.quit_valid  <= 1'b0;
      bus.quit_cause  <= 2'd0;
      bus.quit_code   <= '0;
      bus.done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            max_cycles_q    <= bus.cfg_max_cycles;
            watchdog_q      <= bus.cfg_watchdog;
            trace_start_q   <= bus.cfg_trace_start;
            trace_end_q     <= bus.cfg_trace_end;
            hold_cnt        <= '0;
            bus.cycle_count <= '0;
            bus.cfg_ready   <= 1'b0;
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            idle_cnt        <= '0;
            bus.cycle_count <= '0;
            bus.dut_reset   <= 1'b0;
            bus.trace_en    <= trace_nxt;
            state           <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          bus.cycle_count <= count_inc;
          idle_cnt        <= idle_nxt;
          if (exit_fire || wd_fire || lim_fire) begin
            bus.trace_en   <= 1'b0;
            bus.quit_valid <= 1'b1;
            state          <= QUIT;
            // exit outranks watchdog, which outranks the cycle limit
            if (exit_fire) begin
              bus.quit_cause <= 2'd0;
              bus.quit_code  <= bus.exit_code;
            end else if (wd_fire) begin
              bus.quit_cause <= 2'd1;
              bus.quit_code  <= bus.cycle_count[WORD_W-1:0];
            end else begin
              bus.quit_cause <= 2'd2;
              bus.quit_code  <= bus.cycle_count[WORD_W-1:0];
            end
          end else begin
            bus.trace_en <= trace_nxt;
          end
        end
        QUIT: begin
          if (bus.quit_ready) begin
            bus.quit_valid <= 1'b0;
            bus.done       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cosim_run_ctrl.sv
// Randomized scoreboard bench for cosim_run_ctrl: a run-level reference model
// predicts each finish request, and a negedge monitor checks what the DUT presents.
module tb_cosim_run_ctrl;
  localparam int unsigned RC  = 5;
  localparam int          LEN = 256;

  typedef struct {
    logic [1:0]      cause;
    logic [31:0]     code;
    longint unsigned count;
    int              trace;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  cosim_run_ctrl_if bus ();

  cosim_run_ctrl #(.RESET_CYCLES(RC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Run configuration and per-RUN-cycle stimulus plan
  longint unsigned g_max, g_ts, g_te;
  int unsigned     g_wd;
  bit              plan_r [LEN];
  bit              plan_e [LEN];
  logic [31:0]     plan_code [LEN];

  exp_t sbq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dut_reset"},   64'(bus.dut_reset),   64'd1);
    chk({tag, "_cfg_ready"},   64'(bus.cfg_ready),   64'd1);
    chk({tag, "_trace_en"},    64'(bus.trace_en),    64'd0);
    chk({tag, "_quit_valid"},  64'(bus.quit_valid),  64'd0);
    chk({tag, "_quit_cause"},  64'(bus.quit_cause),  64'd0);
    chk({tag, "_quit_code"},   64'(bus.quit_code),   64'd0);
    chk({tag, "_cycle_count"}, bus.cycle_count,      64'd0);
    chk({tag, "_done"},        64'(bus.done),        64'd0);
  endtask

  // Scan the RUN cycles for the first fire; idle time is the gap since the last retire
  function automatic exp_t model();
    exp_t e;
    int   last_r;
    longint unsigned idle, lo, hi;
    bit   found;
    e.cause = 2'd0; e.code = 32'd0; e.count = 0; e.trace = 0;
    last_r = -1;
    for (int n = 0; n < LEN; n++) begin
      idle  = (last_r < 0) ? longint'(n) : longint'(n - last_r - 1);
      found = 1'b1;
      if (plan_e[n]) begin
        e.cause = 2'd0; e.code = plan_code[n];
      end else if (g_wd != 0 && !plan_r[n] && idle == longint'(g_wd)) begin
        e.cause = 2'd1; e.code = 32'(n);
      end else if (g_max != 0 && longint'(n + 1) == g_max) begin
        e.cause = 2'd2; e.code = 32'(n);
      end else begin
        found = 1'b0;
      end
      if (found) begin
        e.count = longint'(n + 1);
        lo = g_ts;
        hi = (g_te < e.count) ? g_te : e.count;
        e.trace = (hi > lo) ? int'(hi - lo) : 0;
        return e;
      end
      if (plan_r[n]) last_r = n;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard when a finish request appears, then tracks it to done
  exp_t cur;
  bit   in_quit = 1'b0;
  int   trace_seen = 0;
  int   hold_seen = 0;

  always @(negedge clock) begin
    if (reset) begin
      in_quit = 1'b0;
    end else begin
      if (bus.cfg_ready && bus.cfg_valid) begin
        trace_seen = 0;
        hold_seen  = 0;
      end
      if (bus.dut_reset && !bus.cfg_ready) hold_seen++;
      if (bus.trace_en) trace_seen++;
      if (bus.quit_valid && !in_quit) begin
        if (sbq.size() == 0) begin
          chk("unexpected_quit", 64'(bus.quit_valid), 64'd0);
        end else begin
          cur     = sbq.pop_front();
          in_quit = 1'b1;
          chk("quit_cause", 64'(bus.quit_cause), 64'(cur.cause));
          chk("quit_code",  64'(bus.quit_code),  64'(cur.code));
        end
      end else if (bus.quit_valid && in_quit) begin
        chk("quit_cause_stable", 64'(bus.quit_cause), 64'(cur.cause));
        chk("quit_code_stable",  64'(bus.quit_code),  64'(cur.code));
      end
      if (in_quit && bus.done) begin
        chk("done_quit_valid", 64'(bus.quit_valid), 64'd0);
        chk("done_cycle_count", bus.cycle_count, cur.count);
        chk("trace_cycles", 64'(trace_seen), 64'(cur.trace));
        chk("hold_cycles", 64'(hold_seen), 64'(RC));
        in_quit = 1'b0;
      end
    end
  end

  task automatic clear_plans();
    for (int k = 0; k < LEN; k++) begin
      plan_r[k] = 1'b0;
      plan_e[k] = 1'b0;
      plan_code[k] = $urandom;
    end
  endtask

  task automatic scramble_cfg();
    bus.cfg_max_cycles  = {$urandom, $urandom};
    bus.cfg_watchdog    = $urandom;
    bus.cfg_trace_start = {$urandom, $urandom};
    bus.cfg_trace_end   = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    chk_reset_values("reset");
    reset = 1'b0;
  endtask

  // Configure, run to the finish request, hold it for hold_n cycles, then accept or abort
  task automatic run(input int hold_n, input bit abort_quit);
    bit got;
    sbq.push_back(model());
    bus.cfg_valid       = 1'b1;
    bus.cfg_max_cycles  = g_max;
    bus.cfg_watchdog    = g_wd;
    bus.cfg_trace_start = g_ts;
    bus.cfg_trace_end   = g_te;
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
    scramble_cfg();
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.exit_valid   = 1'($urandom_range(0, 1));
      bus.retire_valid = 1'($urandom_range(0, 1));
      bus.quit_ready   = 1'($urandom_range(0, 1));
      bus.cfg_valid    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (!bus.dut_reset) begin got = 1'b1; break; end
    end
    chk("run_started", 64'(got), 64'd1);
    got = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      bus.retire_valid = plan_r[k];
      bus.exit_valid   = plan_e[k];
      bus.exit_code    = plan_code[k];
      bus.cfg_valid    = ($urandom_range(0, 7) == 0);
      bus.quit_ready   = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (bus.quit_valid) begin got = 1'b1; break; end
    end
    bus.retire_valid = 1'b0;
    bus.exit_valid   = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.quit_ready   = 1'b0;
    chk("quit_seen", 64'(got), 64'd1);
    repeat (hold_n) begin
      bus.exit_valid = 1'($urandom_range(0, 1));
      bus.cfg_valid  = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    bus.exit_valid = 1'b0;
    bus.cfg_valid  = 1'b0;
    if (abort_quit) begin
      chk("abort_quit_valid_before", 64'(bus.quit_valid), 64'd1);
      do_reset();
      return;
    end
    bus.quit_ready = 1'b1;
    @(posedge clock); #1;
    bus.quit_ready = 1'b0;
    chk("accept_done", 64'(bus.done), 64'd1);
    chk("accept_quit_valid", 64'(bus.quit_valid), 64'd0);
    @(posedge clock); #1;
    chk("done_terminal", 64'(bus.done), 64'd1);
    chk("done_dut_reset", 64'(bus.dut_reset), 64'd0);
    chk("done_trace_en", 64'(bus.trace_en), 64'd0);
    do_reset();
  endtask

  initial begin
    int dens;
    bus.cfg_valid = 1'b0;
    bus.retire_valid = 1'b0;
    bus.exit_valid = 1'b0;
    bus.exit_code = '0;
    bus.quit_ready = 1'b0;
    scramble_cfg();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_values("por");
    reset = 1'b0;
    @(posedge clock); #1;

    // Limit run, retire every cycle, trace window [10,20), long handshake hold
    clear_plans();
    for (int k = 0; k < LEN; k++) plan_r[k] = 1'b1;
    g_max = 100; g_wd = 0; g_ts = 10; g_te = 20;
    run(20, 1'b0);

    // Watchdog with no activity; inverted trace window
    clear_plans();
    g_max = 0; g_wd = 10; g_ts = 20; g_te = 10;
    run(3, 1'b0);

    // Watchdog delayed by a retire pulse at RUN cycle 8
    clear_plans();
    plan_r[8] = 1'b1;
    g_max = 0; g_wd = 10; g_ts = 0; g_te = 5;
    run(1, 1'b0);

    // Exit, watchdog and limit all fire on RUN cycle 10
    clear_plans();
    plan_e[10] = 1'b1;
    plan_code[10] = 32'h0000_DEAD;
    g_max = 11; g_wd = 10; g_ts = 0; g_te = 64'hFFFF_FFFF_FFFF_FFFF;
    run(0, 1'b0);

    // Shortest possible run
    clear_plans();
    g_max = 1; g_wd = 0; g_ts = 0; g_te = 1;
    run(2, 1'b0);

    // Reset mid-HOLD aborts the run
    clear_plans();
    bus.cfg_valid = 1'b1;
    bus.cfg_max_cycles = 64'd7;
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("hold_mid_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    do_reset();
    @(posedge clock); #1;
    chk("after_hold_abort_idle", 64'(bus.cfg_ready), 64'd1);
    chk("after_hold_abort_dut_reset", 64'(bus.dut_reset), 64'd1);

    // Reset mid-QUIT with the request still pending
    clear_plans();
    g_max = 30; g_wd = 0; g_ts = 5; g_te = 8;
    run(6, 1'b1);
    @(posedge clock); #1;
    chk("after_quit_abort_idle", 64'(bus.cfg_ready), 64'd1);

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      dens = $urandom_range(0, 95);
      for (int k = 0; k < LEN; k++) begin
        plan_r[k]    = ($urandom_range(0, 99) < dens);
        plan_e[k]    = ($urandom_range(0, 59) == 0);
        plan_code[k] = $urandom;
      end
      g_max = longint'($urandom_range(1, 200));
      g_wd  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      g_ts  = longint'($urandom_range(0, 60));
      g_te  = longint'($urandom_range(0, 120));
      run($urandom_range(0, 8), 1'b0);
    end

    repeat (2) @(posedge clock);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
